// File: rtl/execute_stage_pkg.sv
// Shared execute-stage definitions: opcode encodings and the execute FSM states.
// The writeback stage imports this package as well.
package execute_stage_pkg;

  localparam logic [6:0] OP_NOP  = 7'h00;
  localparam logic [6:0] OP_ADD  = 7'h01;
  localparam logic [6:0] OP_SUB  = 7'h02;
  localparam logic [6:0] OP_AND  = 7'h03;
  localparam logic [6:0] OP_OR   = 7'h04;
  localparam logic [6:0] OP_XOR  = 7'h05;
  localparam logic [6:0] OP_SLT  = 7'h06;
  localparam logic [6:0] OP_SLL  = 7'h07;
  localparam logic [6:0] OP_SRL  = 7'h08;
  localparam logic [6:0] OP_ADDI = 7'h09;
  localparam logic [6:0] OP_MUL  = 7'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } exec_state_t;

endpackage

// File: rtl/execute_stage_iter_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_W cycles.
// done pulses on the final iteration; product holds afterwards until the next start.
module iter_multiplier #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic              running;

  assign done = running && (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= a;
      mplier  <= b;
      product <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0])
        product <= product + mcand;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + 1'b1;
      if (done)
        running <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus iterative multiply, with a registered
// valid/ready writeback packet and back-pressure towards decode.
module execute_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SH_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        dst,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [9:0]        offsetlo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_dst,
  output logic [DATA_W-1:0] out_result,
  output logic              out_wr_en,
  output logic              out_illegal,
  output logic              busy
);

  import execute_stage_pkg::*;

  exec_state_t       state, state_nxt;
  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic              load_mul;
  logic [DATA_W-1:0] mul_product;
  logic [4:0]        mul_dst;
  logic [DATA_W-1:0] alu_result;
  logic              alu_wr_en;
  logic              alu_illegal;

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);
  assign load_mul  = (state == ST_DONE) && (!out_valid || out_ready);
  assign busy      = (state != ST_IDLE);

  iter_multiplier #(
    .DATA_W (DATA_W),
    .CNT_W  (SH_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (src1),
    .b       (src2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_result  = '0;
    alu_wr_en   = 1'b1;
    alu_illegal = 1'b0;
    case (opcode)
      OP_NOP:  alu_wr_en  = 1'b0;
      OP_ADD:  alu_result = src1 + src2;
      OP_SUB:  alu_result = src1 - src2;
      OP_AND:  alu_result = src1 & src2;
      OP_OR:   alu_result = src1 | src2;
      OP_XOR:  alu_result = src1 ^ src2;
      OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLL:  alu_result = src1 << src2[SH_W-1:0];
      OP_SRL:  alu_result = src1 >> src2[SH_W-1:0];
      OP_ADDI: alu_result = src1 + {{(DATA_W-10){offsetlo[9]}}, offsetlo};
      OP_MUL:  alu_result = '0;
      default: begin
        alu_wr_en   = 1'b0;
        alu_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mul_start) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_DONE;
      ST_DONE: if (load_mul)  state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            mul_dst <= '0;
    else if (mul_start) mul_dst <= dst;
  end

  // accept and load_mul are exclusive (accept only in IDLE); an accepted MUL
  // still has to drain any packet the consumer takes on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_dst     <= '0;
      out_result  <= '0;
      out_wr_en   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (accept && (opcode != OP_MUL)) begin
      out_valid   <= 1'b1;
      out_dst     <= dst;
      out_result  <= alu_result;
      out_wr_en   <= alu_wr_en;
      out_illegal <= alu_illegal;
    end else if (load_mul) begin
      out_valid   <= 1'b1;
      out_dst     <= mul_dst;
      out_result  <= mul_product;
      out_wr_en   <= 1'b1;
      out_illegal <= 1'b0;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule
